// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM encoding and uio bit map for the serial adder
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int UIO_START = 0;
   localparam int UIO_CIN   = 1;
   localparam int UIO_SUB   = 2;
   localparam int UIO_BUSY  = 0;
   localparam int UIO_DONE  = 1;

   localparam logic [7:0] UIO_OE_MASK = 8'h03;

   // Bit counter must be at least one bit wide, even for single-bit operands.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit combinational full adder
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/tt_um_suhasm_serial_add_ctrl.sv
// rtl/tt_um_suhasm_serial_add_ctrl.sv - bit-serial adder sequencer; SERIAL_ADD_SUB_EN enables A-B
module tt_um_suhasm_serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   sum_sh;
   logic [WIDTH:0]     result;
   logic [CW-1:0]      cnt;
   logic               carry;
   logic               busy;
   logic               done;

   logic               s;
   logic               co;
   logic               sub;
   logic [WIDTH:0]     sum_cat;
   logic [WIDTH-1:0]   sum_next;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               unused_in;

   full_adder_cell u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (s),
      .co (co)
   );

`ifdef SERIAL_ADD_SUB_EN
   assign sub = uio_in[UIO_SUB];
`else
   assign sub = 1'b0;
`endif

   assign op_a     = ui_in[WIDTH-1:0];
   assign op_b     = ui_in[4 +: WIDTH];
   assign sum_cat  = {s, sum_sh};
   assign sum_next = sum_cat[WIDTH:1];
   assign unused_in = ^{ui_in, uio_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         result <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (ena) begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (uio_in[UIO_START]) begin
                  a_sh   <= op_a;
                  b_sh   <= sub ? ~op_b : op_b;
                  carry  <= sub ? 1'b1 : uio_in[UIO_CIN];
                  cnt    <= '0;
                  sum_sh <= '0;
                  state  <= ST_RUN;
                  busy   <= 1'b1;
                  done   <= 1'b0;
               end
            end
            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_next;
               carry  <= co;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  result <= {co, sum_next};
                  state  <= ST_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      uio_out           = '0;
      uio_out[UIO_BUSY] = busy;
      uio_out[UIO_DONE] = done;
   end

   assign uio_oe = UIO_OE_MASK;
   assign uo_out = 8'(result);

endmodule

// File: doc/tt_um_suhasm_serial_add_ctrl.md
# tt_um_suhasm_serial_add_ctrl

Bit-serial adder sequencer for the TinyTapeout tile. It captures two WIDTH-bit operands from `ui_in` and steps a single shared full-adder cell across them LSB-first, one bit per clock. Carry is held in a register between bits. The WIDTH+1-bit result is presented on `uo_out` with a busy/done handshake on the bidirectional pins. It replaces the purely combinational full-adder top and reuses that cell as its only datapath element.

## Interface
- `WIDTH`, default 4: operand width. Legal range is 1..4. A is `ui_in[WIDTH-1:0]` and B is `ui_in[4+WIDTH-1:4]`.
- `clk`  in  1  tile clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  tile enable. While low, all state is frozen.
- `ui_in`  in  8  operands: A in [3:0], B in [7:4].
- `uio_in`  in  8  [0] start, [1] cin, [2] sub (used only with the macro), [7:3] ignored.
- `uio_out`  out  8  [0] busy, [1] done, [7:2] = 0.
- `uio_oe`  out  8  constant 8'b0000_0011.
- `uo_out`  out  8  result: [WIDTH:0] = {carry_out, sum}, upper bits 0.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE when bit counter reaches WIDTH-1 and that bit completes.
  - DONE -> RUN on start=1.
  - No other transitions.
- Load, on a start edge in IDLE or DONE:
  - `a_sh` <= A, `b_sh` <= B (or ~B when subtracting).
  - `carry` <= cin (or 1 when subtracting).
  - `cnt` <= 0, `sum_sh` <= 0.
- Each RUN cycle:
  - Full-adder cell computes s, co from `a_sh[0]`, `b_sh[0]`, `carry`.
  - `sum_sh` shifts right with s entering at bit WIDTH-1.
  - `a_sh` and `b_sh` shift right; `carry` <= co; `cnt` increments.
- Completion, on the final RUN edge: `result` <= {co, sum_sh_next}; done=1.
- `result` holds until the next completion. A new start does not clear `uo_out`.
- Handshake signals:
  - busy=1 exactly while in RUN.
  - done=1 while in DONE; it clears on the start edge that leaves DONE.
- start while in RUN is ignored; the run in progress is not disturbed.
- cin and sub are sampled only on the load edge.
- Arithmetic is modulo 2^(WIDTH+1). There are no overflow flags.
- Reset values (any time, including mid-RUN):
  - state IDLE; all shift registers, `carry`, `cnt` and `result` are 0.
  - `uo_out`=0, `uio_out`=0, `uio_oe`=8'h03.
- ena=0: no register changes, including start capture. Outputs hold their last values.

## Timing
- Start sampled high at edge E0: busy is visible after E0.
- Bits are computed at E1..E_WIDTH.
- done=1 and `uo_out` valid after edge E_WIDTH, a latency of WIDTH+1 edges. For WIDTH=4 that is E4, i.e. 40 ns at 100 MHz.
- Back-to-back: start held high in DONE reloads on the next edge. Throughput is one result per WIDTH+1 cycles.
- ena low for k cycles during RUN extends latency by exactly k cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_ADD_SUB_EN` defined: `uio_in[2]`=1 at load selects A−B.
  - B is inverted and the initial carry is forced to 1; cin is ignored.
  - `uo_out[WIDTH]`=1 means no borrow.
- Undefined: `uio_in[2]` is ignored, and add-with-cin is always performed.

## Structure
- Shared package `serial_add_pkg` holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - `uio` bit-index constants: START=0, CIN=1, SUB=2, BUSY=0, DONE=1.
  - `UIO_OE_MASK`=8'h03.
- One sub-module, `full_adder_cell`: purely combinational, with inputs a, b, ci and outputs s, co. It is instantiated once.
- Counter width is $clog2(WIDTH) with a minimum of 1.

## Test plan
- Add: A=3, B=5, cin=0, start pulse -> busy for 4 cycles, then done=1 and `uo_out`=8'h08.
- Carry propagation: A=F, B=F, cin=1 -> `uo_out`=8'h1F. Counting from E1, done is first seen high after edge E4.
- Start pulsed every cycle during RUN (A=1, B=1) -> result 8'h02, and latency is unchanged.
- Reset:
  - rst_n low at the second RUN cycle -> IDLE with `uo_out`=0, busy=0, done=0 immediately (asynchronous).
  - A fresh start afterwards (A=2, B=2) -> 8'h04.
- ena=0 for 3 cycles mid-run (A=6, B=7) -> done is delayed by exactly 3 cycles and the result is 8'h0D.
- Macro defined, sub=1:
  - A=5, B=3 -> 8'h12.
  - A=3, B=5 -> 8'h0E (borrow, bit4=0).
